keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner and the successor to the fixed 4x4 keypad peripheral. It drives one-hot columns, samples synchronised rows and debounces over whole scan frames. Press and release events are queued in a small FIFO with a valid/ready handshake. It sits between the keypad pins and the CPU I/O-register bus and also exposes a level "currently held key" view.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_event_fifo.sv | 68 ++++++
 rtl/keypad_scanner.sv | 230 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: event record, frame-result encoding
// and the key-code width helper.
package keypad_pkg;

    localparam int MAX_CODE_W = 6;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_KEY   = 2'd1,
        FR_MULTI = 2'd2
    } frame_e;

    typedef struct packed {
        logic                  press;
        logic [MAX_CODE_W-1:0] code;
    } evt_t;

    function automatic int code_w(input int nkeys);
        return (nkeys <= 2) ? 1 : $clog2(nkeys);
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous event FIFO with registered head (valid/head never glitch) and
// a sticky overflow flag for pushes dropped while full.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  evt_t push_data_i,
    input  logic ready_i,
    output logic valid_o,
    output evt_t head_o,
    output logic overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    evt_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             valid_q, overflow_q, overflow_d;
    evt_t             head_q, head_d;
    logic             full, pop, push_ok;

    always_comb begin
        full       = (count_q == (PTR_W+1)'(DEPTH));
        pop        = valid_q && ready_i;
        push_ok    = push_i && (!full || pop);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        count_d    = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        overflow_d = overflow_q || (push_i && full && !pop);
        head_d     = head_q;
        // When the FIFO drains to zero this cycle, the new head is the word being pushed.
        if (count_d != '0) begin
            if ((count_q - (PTR_W+1)'(pop)) == '0) head_d = push_data_i;
            else                                   head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o    = valid_q;
    assign head_o     = head_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, 2-flop row sync, frame-wide
// debounce and an event FIFO. Auto-repeat is built only with KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NROWS          = 4,
    parameter int NCOLS          = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_RATE    = 8,
    localparam int CODE_W        = code_w(NROWS * NCOLS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [NCOLS-1:0]  cols,
    input  logic [NROWS-1:0]  rows,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              evt_press,
    output logic [CODE_W-1:0] evt_code,
    output logic              key_held,
    output logic [CODE_W-1:0] key_code,
    output logic              multi_seen,
    output logic              overflow
);
    localparam int COL_W = $clog2(NCOLS);
    localparam int DW_W  = $clog2(SETTLE_CYCLES);

    logic [NROWS-1:0]  rows_s1_q, rows_s2_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [1:0]        nkeys_q, nkeys_d, colcnt, tot;
    logic [CODE_W-1:0] fcode_q, fcode_d, newcode;
    frame_e            res_q, res_d;
    logic [CODE_W-1:0] res_code_q, res_code_d;
    logic              res_vld_q, res_vld_d;
    logic              acc_held_q, acc_held_d, cand_held_q, cand_held_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d, cand_code_q, cand_code_d;
    logic [3:0]        cnt_q, cnt_d, new_cnt;
    logic              pend_q, pend_d, multi_q, multi_d;
    logic [CODE_W-1:0] pend_code_q, pend_code_d;
    logic              sample, last_col, r_held, accept;
    logic [CODE_W-1:0] r_code;
    int                crow;
    logic              push;
    evt_t              push_data, head;
`ifdef KEYPAD_REPEAT_EN
    logic [15:0]       rep_q, rep_d;
`endif

    always_comb begin
        cols          = '0;
        cols[col_q]   = 1'b1;
        sample        = (dwell_q == DW_W'(SETTLE_CYCLES - 1));
        last_col      = (col_q == COL_W'(NCOLS - 1));
        dwell_d       = sample ? '0 : dwell_q + 1'b1;
        col_d         = col_q;
        if (sample) col_d = last_col ? '0 : col_q + 1'b1;

        colcnt = '0;
        crow   = 0;
        for (int r = 0; r < NROWS; r++) begin
            if (rows_s2_q[r]) begin
                if (colcnt != 2'd2) colcnt = colcnt + 1'b1;
                crow = r;
            end
        end
        // Key count saturates at 2: anything above one key is a ghost/multi frame.
        if (nkeys_q == 2'd0)     tot = colcnt;
        else if (colcnt == 2'd0) tot = nkeys_q;
        else                     tot = 2'd2;
        newcode = (nkeys_q == 2'd0 && colcnt == 2'd1) ? CODE_W'(crow * NCOLS + int'(col_q)) : fcode_q;

        nkeys_d    = nkeys_q;
        fcode_d    = fcode_q;
        res_d      = res_q;
        res_code_d = res_code_q;
        res_vld_d  = 1'b0;
        if (sample) begin
            if (last_col) begin
                res_d      = (tot == 2'd0) ? FR_NONE : (tot == 2'd1) ? FR_KEY : FR_MULTI;
                res_code_d = (tot == 2'd1) ? newcode : '0;
                res_vld_d  = 1'b1;
                nkeys_d    = '0;
                fcode_d    = '0;
            end else begin
                nkeys_d = tot;
                fcode_d = newcode;
            end
        end
    end

    always_comb begin
        r_held      = (res_q == FR_KEY);
        r_code      = r_held ? res_code_q : '0;
        acc_held_d  = acc_held_q;
        acc_code_d  = acc_code_q;
        cand_held_d = cand_held_q;
        cand_code_d = cand_code_q;
        cnt_d       = cnt_q;
        new_cnt     = '0;
        accept      = 1'b0;
        multi_d     = multi_q || (res_vld_q && res_q == FR_MULTI);
        if (res_vld_q) begin
            if (r_held == acc_held_q && r_code == acc_code_q) begin
                cnt_d = '0;
            end else begin
                if (cnt_q != '0 && r_held == cand_held_q && r_code == cand_code_q) begin
                    new_cnt = cnt_q + 1'b1;
                end else begin
                    cand_held_d = r_held;
                    cand_code_d = r_code;
                    new_cnt     = 4'd1;
                end
                if (new_cnt == 4'(DEBOUNCE_SCANS)) begin
                    accept     = 1'b1;
                    acc_held_d = r_held;
                    acc_code_d = r_code;
                    cnt_d      = '0;
                end else begin
                    cnt_d = new_cnt;
                end
            end
        end

        push        = 1'b0;
        push_data   = '0;
        pend_d      = 1'b0;
        pend_code_d = pend_code_q;
        if (pend_q) begin
            push      = 1'b1;
            push_data = '{press: 1'b1, code: MAX_CODE_W'(pend_code_q)};
        end
        // Key-to-key rollover: release now, press of the new key one cycle later.
        if (accept) begin
            push = 1'b1;
            if (acc_held_q && r_held) begin
                push_data   = '{press: 1'b0, code: MAX_CODE_W'(acc_code_q)};
                pend_d      = 1'b1;
                pend_code_d = r_code;
            end else if (r_held) begin
                push_data = '{press: 1'b1, code: MAX_CODE_W'(r_code)};
            end else begin
                push_data = '{press: 1'b0, code: MAX_CODE_W'(acc_code_q)};
            end
        end
`ifdef KEYPAD_REPEAT_EN
        rep_d = rep_q;
        if (accept) begin
            rep_d = r_held ? 16'(REPEAT_DELAY) : '0;
        end else if (res_vld_q && acc_held_q) begin
            if (rep_q == 16'd1) begin
                push      = 1'b1;
                push_data = '{press: 1'b1, code: MAX_CODE_W'(acc_code_q)};
                rep_d     = 16'(REPEAT_RATE);
            end else if (rep_q != '0) begin
                rep_d = rep_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_s1_q   <= '0;
            rows_s2_q   <= '0;
            col_q       <= '0;
            dwell_q     <= '0;
            nkeys_q     <= '0;
            fcode_q     <= '0;
            res_q       <= FR_NONE;
            res_code_q  <= '0;
            res_vld_q   <= 1'b0;
            acc_held_q  <= 1'b0;
            acc_code_q  <= '0;
            cand_held_q <= 1'b0;
            cand_code_q <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_code_q <= '0;
            multi_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            rows_s1_q   <= rows;
            rows_s2_q   <= rows_s1_q;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            nkeys_q     <= nkeys_d;
            fcode_q     <= fcode_d;
            res_q       <= res_d;
            res_code_q  <= res_code_d;
            res_vld_q   <= res_vld_d;
            acc_held_q  <= acc_held_d;
            acc_code_q  <= acc_code_d;
            cand_held_q <= cand_held_d;
            cand_code_q <= cand_code_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            multi_q     <= multi_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    keypad_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_data),
        .ready_i    (evt_ready),
        .valid_o    (evt_valid),
        .head_o     (head),
        .overflow_o (overflow)
    );

    assign evt_press  = head.press;
    assign evt_code   = CODE_W'(head.code);
    assign key_held   = acc_held_q;
    assign key_code   = acc_code_q;
    assign multi_seen = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (defaults: 4x4, 16-clock frames).
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       evt_valid, evt_ready, evt_press;
    logic [3:0] evt_code;
    logic       key_held;
    logic [3:0] key_code;
    logic       multi_seen, overflow;
    logic [15:0] pressed;

    typedef struct {
        logic       press;
        logic [3:0] code;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    keypad_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .cols      (cols),
        .rows      (rows),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_press (evt_press),
        .evt_code  (evt_code),
        .key_held  (key_held),
        .key_code  (key_code),
        .multi_seen(multi_seen),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads high when a pressed key sits on a driven column.
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++) rows[r] = |(pressed[r*4 +: 4] & cols);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && evt_valid && evt_ready) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got press=%0b code=%0d, expected none", evt_press, evt_code);
            end else begin
                e = expq.pop_front();
                if (evt_press !== e.press || evt_code !== e.code) begin
                    fails++;
                    $display("FAIL event_order: got press=%0b code=%0d, expected press=%0b code=%0d",
                             evt_press, evt_code, e.press, e.code);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first clock of a frame (column 0, dwell 0).
    task automatic align_frame();
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cols == 4'b1000) begin found = 1; break; end
        end
        if (found) begin
            found = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (cols == 4'b0001) begin found = 1; break; end
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL align_frame: got cols=%b, expected frame start within bound", cols);
        end
    endtask

    task automatic test_reset();
        cycles(7);
        rst = 1'b1;
        cycles(2);
        tests += 6;
        if (cols !== 4'b0001) begin fails++; $display("FAIL reset_cols: got %b, expected 0001", cols); end
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_evt_valid: got %b, expected 0", evt_valid); end
        if (key_held !== 1'b0) begin fails++; $display("FAIL reset_key_held: got %b, expected 0", key_held); end
        if (key_code !== 4'd0) begin fails++; $display("FAIL reset_key_code: got %0d, expected 0", key_code); end
        if (multi_seen !== 1'b0) begin fails++; $display("FAIL reset_multi_seen: got %b, expected 0", multi_seen); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        rst = 1'b0;
        cycles(1);
        tests += 2;
        if (cols !== 4'b0001) begin fails++; $display("FAIL post_reset_cols: got %b, expected 0001", cols); end
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL post_reset_evt_valid: got %b, expected 0", evt_valid); end
    endtask

    task automatic test_clean_press();
        int lat = -1;
        evt_ready = 1'b1;
        align_frame();
        pressed = 16'h0040;
        expq.push_back('{1'b1, 4'd6});
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (evt_valid) begin lat = n; break; end
        end
        tests += 3;
        if (lat != 49) begin fails++; $display("FAIL press_latency: got %0d clocks, expected 49", lat); end
        if (key_held !== 1'b1) begin fails++; $display("FAIL press_key_held: got %b, expected 1", key_held); end
        if (key_code !== 4'd6) begin fails++; $display("FAIL press_key_code: got %0d, expected 6", key_code); end
        cycles(16 * 3);
        pressed = 16'h0000;
        expq.push_back('{1'b0, 4'd6});
        cycles(16 * 6);
        tests += 3;
        if (key_held !== 1'b0) begin fails++; $display("FAIL release_key_held: got %b, expected 0", key_held); end
        if (key_code !== 4'd0) begin fails++; $display("FAIL release_key_code: got %0d, expected 0", key_code); end
        if (expq.size() != 0) begin fails++; $display("FAIL release_events: got %0d pending, expected 0", expq.size()); end
    endtask

    task automatic test_bounce();
        align_frame();
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            cycles(16);
        end
        pressed = 16'h0000;
        cycles(32);
        tests += 2;
        if (key_held !== 1'b0) begin fails++; $display("FAIL bounce_key_held: got %b, expected 0", key_held); end
        if (expq.size() != 0) begin fails++; $display("FAIL bounce_events: got %0d pending, expected 0", expq.size()); end
    endtask

    task automatic test_ghost();
        pressed = 16'h0011;
        cycles(16 * 5);
        tests += 2;
        if (multi_seen !== 1'b1) begin fails++; $display("FAIL ghost_multi_seen: got %b, expected 1", multi_seen); end
        if (key_held !== 1'b0) begin fails++; $display("FAIL ghost_key_held: got %b, expected 0", key_held); end
        pressed = 16'h0000;
        cycles(32);
        tests++;
        if (multi_seen !== 1'b1) begin fails++; $display("FAIL ghost_sticky: got %b, expected 1", multi_seen); end
    endtask

    task automatic test_rollover();
        bit found = 0;
        evt_ready = 1'b1;
        pressed = 16'h0001;
        expq.push_back('{1'b1, 4'd0});
        cycles(16 * 5);
        tests++;
        if (key_held !== 1'b1) begin fails++; $display("FAIL roll_first_held: got %b, expected 1", key_held); end
        expq.push_back('{1'b0, 4'd0});
        expq.push_back('{1'b1, 4'd5});
        pressed = 16'h0020;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (evt_valid) begin found = 1; break; end
        end
        tests++;
        if (!found) begin fails++; $display("FAIL roll_timeout: got no event, expected release within 120 clocks"); end
        @(negedge clk);
        tests += 2;
        if (evt_valid !== 1'b1 || evt_press !== 1'b1 || evt_code !== 4'd5) begin
            fails++;
            $display("FAIL roll_consecutive: got valid=%b press=%b code=%0d, expected valid=1 press=1 code=5",
                     evt_valid, evt_press, evt_code);
        end
        if (key_code !== 4'd5) begin fails++; $display("FAIL roll_key_code: got %0d, expected 5", key_code); end
        pressed = 16'h0000;
        expq.push_back('{1'b0, 4'd5});
        cycles(16 * 6);
        tests++;
        if (expq.size() != 0) begin fails++; $display("FAIL roll_events: got %0d pending, expected 0", expq.size()); end
    endtask

    task automatic test_overflow();
        logic [15:0] seq_keys [5];
        seq_keys = '{16'h0008, 16'h0000, 16'h0200, 16'h0000, 16'h1000};
        evt_ready = 1'b0;
        expq.push_back('{1'b1, 4'd3});
        expq.push_back('{1'b0, 4'd3});
        expq.push_back('{1'b1, 4'd9});
        expq.push_back('{1'b0, 4'd9});
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                tests++;
                if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b, expected 0", overflow); end
            end
            pressed = seq_keys[i];
            cycles(16 * 5);
        end
        tests += 2;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
        if (evt_valid !== 1'b1 || evt_press !== 1'b1 || evt_code !== 4'd3) begin
            fails++;
            $display("FAIL ovf_head: got valid=%b press=%b code=%0d, expected valid=1 press=1 code=3",
                     evt_valid, evt_press, evt_code);
        end
        evt_ready = 1'b1;
        cycles(8);
        tests += 3;
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b, expected 0", evt_valid); end
        if (expq.size() != 0) begin fails++; $display("FAIL drain_count: got %0d pending, expected 0", expq.size()); end
        if (evt_press !== 1'b0 || evt_code !== 4'd9) begin
            fails++;
            $display("FAIL empty_hold: got press=%b code=%0d, expected press=0 code=9", evt_press, evt_code);
        end
        pressed = 16'h0000;
        expq.push_back('{1'b0, 4'd12});
        cycles(16 * 6);
        tests++;
        if (expq.size() != 0) begin fails++; $display("FAIL ovf_release: got %0d pending, expected 0", expq.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        evt_ready = 1'b0;
        pressed   = 16'h0000;
        cycles(3);
        rst = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_rollover();
        test_overflow();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
